// File: rtl/param_pipelined_data_path.sv
// Two-stage register-file + ALU datapath: operand read with result
// forwarding, then execute and writeback with registered result/flags.
module param_pipelined_data_path #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic [AW-1:0]   read_reg_num1,
  input  logic [AW-1:0]   read_reg_num2,
  input  logic [AW-1:0]   write_reg,
  input  logic [3:0]      alu_control,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            regwrite,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            out_valid,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d;
  logic [XLEN-1:0] s1_b_q, s1_b_d;
  logic [3:0]      s1_op_q, s1_op_d;
  logic [AW-1:0]   s1_rd_q, s1_rd_d;
  logic            s1_we_q, s1_we_d;

  logic [XLEN-1:0] res_q, res_d;
  logic            zf_q, zf_d;
  logic            ov_q, ov_d;

  logic [XLEN-1:0] alu_out;
  logic [SW-1:0]   shamt;
  logic            wb_en;
  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op_a, op_b;

  always_comb begin
    alu_out = '0;
    shamt   = s1_b_q[SW-1:0];
    unique case (s1_op_q)
      4'b0000: alu_out = s1_a_q & s1_b_q;
      4'b0001: alu_out = s1_a_q | s1_b_q;
      4'b0010: alu_out = s1_a_q + s1_b_q;
      4'b0011: alu_out = s1_a_q ^ s1_b_q;
      4'b0100: alu_out = {{(XLEN-1){1'b0}}, s1_a_q < s1_b_q};
      4'b0110: alu_out = s1_a_q - s1_b_q;
      4'b0111: alu_out = {{(XLEN-1){1'b0}},
                          $signed(s1_a_q) < $signed(s1_b_q)};
      4'b1000: alu_out = s1_a_q << shamt;
      4'b1001: alu_out = s1_a_q >> shamt;
      4'b1010: alu_out = $unsigned($signed(s1_a_q) >>> shamt);
      4'b1100: alu_out = ~(s1_a_q | s1_b_q);
      default: alu_out = '0;
    endcase
  end

  assign wb_en = s1_valid_q & s1_we_q & (s1_rd_q != '0);

  // In-flight result overrides the file so dependents need no bubble
  always_comb begin
    fwd_a   = wb_en & (s1_rd_q == read_reg_num1);
    fwd_b   = wb_en & (s1_rd_q == read_reg_num2) & ~use_imm;
    rs1_val = (read_reg_num1 == '0) ? '0 : rf_q[read_reg_num1];
    rs2_val = (read_reg_num2 == '0) ? '0 : rf_q[read_reg_num2];
    op_a    = fwd_a ? alu_out : rs1_val;
    op_b    = use_imm ? imm : (fwd_b ? alu_out : rs2_val);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) rf_d[i] = rf_q[i];
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_we_d    = s1_we_q;
    res_d      = res_q;
    zf_d       = zf_q;
    ov_d       = ov_q;
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_d[i] = '0;
      s1_valid_d = 1'b0;
      s1_a_d     = '0;
      s1_b_d     = '0;
      s1_op_d    = '0;
      s1_rd_d    = '0;
      s1_we_d    = 1'b0;
      res_d      = '0;
      zf_d       = 1'b0;
      ov_d       = 1'b0;
    end else if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = op_a;
        s1_b_d  = op_b;
        s1_op_d = alu_control;
        s1_rd_d = write_reg;
        s1_we_d = regwrite;
      end
      ov_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = alu_out;
        zf_d  = (alu_out == '0);
      end
      if (wb_en) rf_d[s1_rd_q] = alu_out;
    end
  end

  always_ff @(posedge clock) begin
    rf_q       <= rf_d;
    s1_valid_q <= s1_valid_d;
    s1_a_q     <= s1_a_d;
    s1_b_q     <= s1_b_d;
    s1_op_q    <= s1_op_d;
    s1_rd_q    <= s1_rd_d;
    s1_we_q    <= s1_we_d;
    res_q      <= res_d;
    zf_q       <= zf_d;
    ov_q       <= ov_d;
  end

  assign result    = res_q;
  assign zero_flag = zf_q;
  assign out_valid = ov_q;
  assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_param_pipelined_data_path.sv
// Directed bench for param_pipelined_data_path with an
// architectural (in-order, sequential) reference model.
module tb_param_pipelined_data_path;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            stall;
  logic [AW-1:0]   read_reg_num1;
  logic [AW-1:0]   read_reg_num2;
  logic [AW-1:0]   write_reg;
  logic [3:0]      alu_control;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic            regwrite;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            out_valid;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  param_pipelined_data_path #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control),
    .use_imm(use_imm), .imm(imm), .regwrite(regwrite),
    .result(result), .zero_flag(zero_flag), .out_valid(out_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // arch: program-order register values; comm: what the file holds now
  logic [XLEN-1:0] arch [NREGS];
  logic [XLEN-1:0] comm [NREGS];
  bit              pend_v;
  int              pend_rd;
  bit              pend_we;
  logic [XLEN-1:0] pend_val;
  bit              exp_ov;
  logic [XLEN-1:0] exp_res;
  bit              exp_zf;

  task automatic chk(string name, logic [XLEN-1:0] got,
                     logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_alu(
      logic [3:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    int sh = int'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return (a < b) ? 1 : 0;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return $unsigned($signed(a) >>> sh);
      4'd12: return ~(a | b);
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    logic [XLEN-1:0] a, b, v;
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        arch[i] = 0;
        comm[i] = 0;
      end
      pend_v = 0;
      exp_ov = 0;
      exp_res = 0;
      exp_zf = 0;
    end else if (!stall) begin
      exp_ov = pend_v;
      if (pend_v) begin
        exp_res = pend_val;
        exp_zf = (pend_val == 0);
        if (pend_we && pend_rd != 0) comm[pend_rd] = pend_val;
      end
      pend_v = in_valid;
      if (in_valid) begin
        a = arch[read_reg_num1];
        b = use_imm ? imm : arch[read_reg_num2];
        v = ref_alu(alu_control, a, b);
        pend_rd = int'(write_reg);
        pend_we = regwrite;
        pend_val = v;
        if (regwrite && write_reg != 0) arch[write_reg] = v;
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("result", result, exp_res);
      chk("zero_flag", {31'd0, zero_flag}, {31'd0, exp_zf});
      chk("dbg_data", dbg_data, comm[dbg_addr]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(logic [3:0] op, int rd, int rs1, int rs2,
                       bit ui, logic [XLEN-1:0] iv, bit we);
    in_valid = 1;
    stall = 0;
    alu_control = op;
    write_reg = AW'(rd);
    read_reg_num1 = AW'(rs1);
    read_reg_num2 = AW'(rs2);
    use_imm = ui;
    imm = iv;
    regwrite = we;
    cyc();
  endtask

  task automatic idle();
    in_valid = 0;
    stall = 0;
    cyc();
  endtask

  task automatic dbg(string name, int r, logic [XLEN-1:0] exp);
    dbg_addr = AW'(r);
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    reset = 0;
    in_valid = 0;
    stall = 0;
    read_reg_num1 = 0;
    read_reg_num2 = 0;
    write_reg = 0;
    alu_control = 0;
    use_imm = 0;
    imm = 0;
    regwrite = 0;
    dbg_addr = 0;
    for (int i = 0; i < NREGS; i++) begin
      arch[i] = 'x;
      comm[i] = 'x;
    end
    pend_v = 0;
    pend_rd = 0;
    pend_we = 0;
    pend_val = 0;
    cyc();
    chk_en = 1;
    cyc();
    reset = 1;

    // 1: writes, then reset wipes the file
    issue(4'd2, 12, 0, 0, 1, 32'h1234, 1);
    issue(4'd2, 13, 0, 0, 1, 32'h55, 1);
    idle();
    dbg("pre_rst_r12", 12, 32'h1234);
    reset = 0;
    cyc();
    cyc();
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_zf", {31'd0, zero_flag}, 32'd0);
    for (int i = 0; i < NREGS; i++) dbg("rst_dbg", i, 32'd0);
    reset = 1;
    idle();

    // 2: immediate fill and wrap
    issue(4'd2, 1, 0, 0, 1, 32'd5, 1);
    issue(4'd2, 2, 0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("fill_r1", result, 32'd5);
    issue(4'd2, 3, 1, 2, 0, 32'd0, 1);
    chk("fill_r2", result, 32'hFFFF_FFFF);
    idle();
    chk("wrap_res", result, 32'd4);
    chk("wrap_zf", {31'd0, zero_flag}, 32'd0);
    dbg("dbg_r3", 3, 32'd4);

    // 3: back-to-back forwarding
    issue(4'd2, 1, 0, 0, 1, 32'd7, 1);
    issue(4'd2, 1, 1, 1, 0, 32'd0, 1);
    chk("fwd_7", result, 32'd7);
    issue(4'd6, 4, 1, 1, 0, 32'd0, 1);
    chk("fwd_14", result, 32'd14);
    idle();
    chk("fwd_sub", result, 32'd0);
    chk("fwd_zf", {31'd0, zero_flag}, 32'd1);

    // 4: r0 write dropped and not forwarded
    issue(4'd2, 0, 0, 0, 1, 32'd9, 1);
    issue(4'd2, 6, 0, 0, 0, 32'd0, 1);
    chk("r0_res", result, 32'd9);
    chk("r0_ov", {31'd0, out_valid}, 32'd1);
    idle();
    chk("r0_read", result, 32'd0);
    dbg("dbg_r0", 0, 32'd0);

    // 5: stall freezes everything
    issue(4'd2, 5, 0, 0, 1, 32'd3, 1);
    dbg_addr = 5;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1;
      stall = 1;
      alu_control = 4'($urandom_range(0, 15));
      write_reg = 5;
      read_reg_num1 = AW'($urandom_range(0, 31));
      use_imm = 1;
      imm = $urandom;
      regwrite = 1;
      cyc();
      chk("stall_ov", {31'd0, out_valid}, 32'd0);
      chk("stall_r5", dbg_data, 32'd0);
    end
    idle();
    chk("stall_res", result, 32'd3);
    chk("stall_ov1", {31'd0, out_valid}, 32'd1);
    idle();
    chk("stall_once", {31'd0, out_valid}, 32'd0);

    // 6: ops
    issue(4'd2, 7, 0, 0, 1, 32'hFFFF_FFFF, 1);
    issue(4'd2, 8, 0, 0, 1, 32'd1, 1);
    issue(4'd7, 9, 7, 8, 0, 32'd0, 1);
    issue(4'd4, 9, 7, 8, 0, 32'd0, 1);
    chk("slt", result, 32'd1);
    issue(4'd2, 10, 0, 0, 1, 32'h8000_0000, 1);
    chk("sltu", result, 32'd0);
    issue(4'd10, 11, 10, 0, 1, 32'd4, 1);
    issue(4'd15, 12, 7, 8, 0, 32'd0, 1);
    chk("sra", result, 32'hF800_0000);
    issue(4'd8, 13, 8, 0, 1, 32'd35, 1);
    chk("op15", result, 32'd0);
    chk("op15_zf", {31'd0, zero_flag}, 32'd1);
    idle();
    chk("sll_mask", result, 32'd8);

    // reset with an instruction in stage 1
    issue(4'd2, 14, 0, 0, 1, 32'h55, 1);
    reset = 0;
    in_valid = 0;
    cyc();
    chk("mid_ov", {31'd0, out_valid}, 32'd0);
    dbg("mid_r14", 14, 32'd0);
    reset = 1;
    idle();
    chk("mid_ov2", {31'd0, out_valid}, 32'd0);
    dbg("mid_r14b", 14, 32'd0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_pipelined_data_path.md
Name: param_pipelined_data_path

Overview:
Two-stage pipelined register-file + ALU datapath, parametrised in data width and register count. Successor to the single-cycle register-register datapath. Adds:
- an immediate operand mode
- a valid/stall handshake
- internal result forwarding
- a registered result and flags
- a debug read port

Sits between the decode/control unit and the writeback path of the core.

Parameters:
XLEN, 32, data width of registers, operands and result (≥8)
NREGS, 32, number of architectural registers (power of 2, ≥2); register 0 hardwired to zero
AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (sampled on rising edge of clock)
in_valid  in  1  instruction present on inputs this cycle
stall  in  1  freeze entire pipeline this cycle
read_reg_num1  in  AW  source register 1
read_reg_num2  in  AW  source register 2
write_reg  in  AW  destination register
alu_control  in  4  ALU operation
use_imm  in  1  1 = operand B is imm, 0 = register 2
imm  in  XLEN  immediate operand
regwrite  in  1  write result to write_reg
result  out  XLEN  registered ALU result
zero_flag  out  1  registered (result == 0)
out_valid  out  1  result/zero_flag valid this cycle
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  combinational read of register dbg_addr (0 when dbg_addr = 0)

Behaviour:
- Reset (reset = 0 at rising edge):
  - all registers ← 0
  - stage-1 and stage-2 valids ← 0
  - result ← 0, zero_flag ← 0, out_valid ← 0
  - no register write that cycle
  - reset wins over stall and in_valid; instructions in flight are discarded
- Stage 1 (operand read), on an edge with reset = 1 and stall = 0:
  - s1_valid ← in_valid
  - if in_valid: latch opA, opB, alu_control, write_reg, regwrite
  - opA = rf[read_reg_num1]
  - opB = use_imm ? imm : rf[read_reg_num2]
  - register 0 always reads 0
- Forwarding (combinational, at the stage-1 read):
  - condition: s1_valid & s1_regwrite & s1_rd != 0 & s1_rd == the source address
  - when true, the source takes the current ALU output instead of the file value
  - applies independently to each source; opB forwarding is suppressed when use_imm = 1
  - gives back-to-back dependent instructions correct values with no bubble
- Stage 2 (execute/writeback), same edge as stage 1, reset = 1, stall = 0:
  - out_valid ← s1_valid
  - if s1_valid: result ← alu_out, zero_flag ← (alu_out == 0)
  - if s1_valid & s1_regwrite & s1_rd != 0: rf[s1_rd] ← alu_out
  - writes to register 0 are dropped
- Hold behaviour: when s1_valid = 0, result and zero_flag hold their previous values.
- Latency: instruction presented at edge N → result/out_valid visible after edge N+1; register file updated at edge N+1.
- Throughput: one instruction per cycle.
- Stall = 1 (with reset = 1):
  - no stage advances, no register write
  - inputs are ignored
  - all outputs hold, including out_valid
  - forwarding state is preserved
- ALU (operands opA, opB; result truncated to XLEN):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^XLEN)
  - 0011 XOR
  - 0100 SLTU
  - 0110 SUB (wraps)
  - 0111 SLT (signed, result 1/0)
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1100 NOR
  - all others → 0
  - shifts use opB[$clog2(XLEN)-1:0] only
- dbg_data: combinational read of the file; does not see forwarding or an in-flight write.

Test Plan:
1. Reset: hold reset = 0 for 2 cycles after arbitrary writes → every dbg_data read = 0, out_valid = 0, result = 0, zero_flag = 0.
2. Immediate fill: ADD r1 = r0 + imm 5, then ADD r2 = r0 + imm 0xFFFFFFFF → result 5, then 0xFFFFFFFF; then ADD r3 = r1 + r2 → result 4 (wrap), zero_flag = 0; dbg r3 = 4.
3. Back-to-back forwarding:
   - ADD r1 = r0 + imm 7, next cycle ADD r1 = r1 + r1, next cycle SUB r4 = r1 − r1 → results 7, 14, 0 on consecutive cycles
   - zero_flag = 1 on the SUB
4. Register 0 write: regwrite to r0 with ADD imm 9 → result 9, out_valid = 1; dbg r0 = 0; a following read of r0 gives 0 (no forwarding from r0).
5. Stall: issue ADD r5 = r0 + imm 3, stall = 1 for 3 cycles with in_valid = 1 and garbage inputs → outputs frozen, dbg r5 unchanged until stall drops; then result 3 exactly once.
6. Ops/reset mid-flight:
   - SLT with −1 vs 1 → 1; SLTU → 0; SRA 0x80000000 by 4 → 0xF8000000; op 1111 → 0, zero_flag = 1
   - assert reset while an instruction is in stage 1 → no write occurs, out_valid = 0 next cycle
